// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode multi-digit
// seven-segment display. Double-buffers a hex value and decimal-point mask,
// swaps buffers only on frame boundaries, and scans one digit per slot with
// a blanking interval at the start of each slot.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    update_pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pend;

  logic                    frame_end;
  logic                    in_blank;
  logic                    lz_hit;
  logic                    show;
  logic [3:0]              nibble;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign nibble    = shadow_value[4*idx +: 4];

  // Blanking window covers the first BLANK_CYCLES counts of every slot
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYCLES));
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // lz_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 exempt
  logic [NUM_DIGITS-1:0] lz_zero;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
        assign lz_zero[gi] = 1'b0;
      end else begin : g_dn
        assign lz_zero[gi] = ~|shadow_value[4*NUM_DIGITS-1:4*gi];
      end
    end
  endgenerate
  assign lz_hit = lz_zero[idx];
`else
  assign lz_hit = 1'b0;
`endif

  assign show = !in_blank && digit_en[idx] && !lz_hit;

  // Slot counter, digit index, and the pending/shadow double buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      pend         <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_mask;
      end

      // A boundary load bypasses pending and goes straight to the shadow
      if (frame_end && (load || pend)) begin
        shadow_value <= load ? value : pend_value;
        shadow_dp    <= load ? dp_mask : pend_dp;
        pend         <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  // Registered display outputs derived from the state sampled on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= '1;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= show ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg         <= show ? decode(nibble) : 7'b1111111;
      dp          <= show ? ~shadow_dp[idx] : 1'b1;
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

  assign update_pending = pend;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// A frame-position reference model checks every cycle; table vectors and
// hand sequences check the corner cases at chosen points in the scan.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int B  = 2;
  localparam int FL = N * R;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        update_pending;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
    .digit_en(digit_en), .seg(seg), .dp(dp), .an(an),
    .frame_start(frame_start), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame as one integer
  int          m_pos;
  int          m_dig;
  int          m_off;
  bit          m_lit;
  logic [15:0] m_shadow, m_pending;
  logic [3:0]  m_shadow_dp, m_pending_dp;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;
  logic [3:0]  one4 = 4'b0001;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_shadow <= '0; m_pending <= '0; m_shadow_dp <= '0;
      m_pending_dp <= '0; m_pend <= 1'b0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_fs <= 1'b0;
    end else begin
      m_dig = m_pos / R;
      m_off = m_pos % R;
      m_lit = (m_off >= B) && digit_en[m_dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_dig >= 1 && (m_shadow >> (4 * m_dig)) == 16'h0) m_lit = 0;
`endif
      e_an  <= m_lit ? ~(one4 << m_dig) : 4'hF;
      e_seg <= m_lit ? HEX[m_shadow[4*m_dig +: 4]] : 7'h7F;
      e_dp  <= m_lit ? ~m_shadow_dp[m_dig] : 1'b1;
      e_fs  <= (m_pos == 0);
      if (load) begin
        m_pending <= value; m_pending_dp <= dp_mask;
      end
      if (m_pos == FL - 1) begin
        if (load) begin
          m_shadow <= value; m_shadow_dp <= dp_mask;
        end else if (m_pend) begin
          m_shadow <= m_pending; m_shadow_dp <= m_pending_dp;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_pend <= 1'b1;
      end
      m_pos <= (m_pos + 1) % FL;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en)
      chk("model_outputs", {19'b0, an, seg, dp, frame_start, update_pending},
          {19'b0, e_an, e_seg, e_dp, e_fs, m_pend});
  end

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic [3:0]  dpn;    // expected active-low dp per digit
    logic [3:0]  shown;
  } vec_t;

  vec_t vecs [6];

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    bit ok;
    int i;
    ok = 0;
    i = 0;
    while (!ok && i < 80) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1;
      i++;
    end
    if (!ok) chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_mask = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_digit(input string name, input int d, input logic [6:0] s,
                             input logic dpn, input bit sh);
    logic [3:0] ea;
    ea = sh ? ~(one4 << d) : 4'hF;
    chk({name, "_an"}, {28'b0, an}, {28'b0, ea});
    chk({name, "_seg"}, {25'b0, seg}, {25'b0, (sh ? s : 7'h7F)});
    chk({name, "_dp"}, {31'b0, dp}, {31'b0, (sh ? dpn : 1'b1)});
  endtask

  initial begin
    int cur, tgt, fs_count;
    vecs[0] = '{16'h12AF, 4'b0100, 4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 4'b1111};
    vecs[1] = '{16'h2222, 4'b0000, 4'b1010, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'b1010};
    vecs[2] = '{16'h3456, 4'b1001, 4'hF, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0110, 4'b1111};
    vecs[3] = '{16'h789B, 4'b0010, 4'hF, {7'h78, 7'h00, 7'h10, 7'h03}, 4'b1101, 4'b1111};
    vecs[4] = '{16'hCDEF, 4'b1111, 4'b0101, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1010, 4'b0101};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[5] = '{16'h0050, 4'b0000, 4'hF, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111, 4'b0011};
`else
    vecs[5] = '{16'h0050, 4'b0000, 4'hF, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111, 4'b1111};
`endif

    // Reset state
    skip(3);
    chk_en = 1;
    chk("reset_outputs", {25'b0, an, dp, frame_start, update_pending}, {25'b0, 4'hF, 3'b100});
    chk("reset_seg", {25'b0, seg}, {25'b0, 7'h7F});
    rst = 1'b0;

    // Free run: frame_start pulses once per 32 cycles
    fs_count = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_start) fs_count++;
    end
    chk("free_run_frame_starts", fs_count, 2);

    // Table vectors: load mid-frame, check each digit in the next frame
    for (int v = 0; v < 6; v++) begin
      wait_fs();
      skip(5);
      digit_en = vecs[v].en;
      pulse_load(vecs[v].value, vecs[v].dp);
      chk($sformatf("vec%0d_pending", v), {31'b0, update_pending}, 32'd1);
      wait_fs();
      cur = 0;
      for (int d = 0; d < 4; d++) begin
        tgt = 8 * d + 4;
        skip(tgt - cur);
        cur = tgt;
        check_digit($sformatf("vec%0d_d%0d", v, d), d, vecs[v].segs[7*d +: 7],
                    vecs[v].dpn[d], vecs[v].shown[d]);
      end
      $display("vector %0d value=%h dp=%b en=%b checked", v, vecs[v].value, vecs[v].dp, vecs[v].en);
    end
    digit_en = 4'hF;

    // Two loads in one frame: the last one wins
    wait_fs();
    skip(3);
    pulse_load(16'h1111, 4'b0000);
    skip(4);
    pulse_load(16'h2222, 4'b0000);
    wait_fs();
    skip(4);
    check_digit("double_load_d0", 0, 7'h24, 1'b1, 1'b1);
    skip(8);
    check_digit("double_load_d1", 1, 7'h24, 1'b1, 1'b1);

    // Load on the exact boundary edge: straight to shadow, pending stays 0
    wait_fs();
    skip(30);
    value = 16'h3A5C; dp_mask = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("boundary_load_no_pending", {31'b0, update_pending}, 32'd0);
    @(negedge clk);
    chk("boundary_load_frame_start", {31'b0, frame_start}, 32'd1);
    skip(4);
    check_digit("boundary_load_d0", 0, 7'h46, 1'b0, 1'b1);
    chk("boundary_load_pending_after", {31'b0, update_pending}, 32'd0);

    // Asynchronous reset during the digit-2 slot
    wait_fs();
    skip(20);
    chk("pre_reset_digit2_lit", {28'b0, an}, 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_an", {28'b0, an}, 32'hF);
    chk("async_reset_seg_dp", {24'b0, seg, dp}, {24'b0, 7'h7F, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_frame_start", {31'b0, frame_start}, 32'd1);
    skip(4);
    check_digit("post_reset_d0", 0, 7'h40, 1'b1, 1'b1);
    skip(8);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_digit("post_reset_d1", 1, 7'h40, 1'b1, 1'b0);
`else
    check_digit("post_reset_d1", 1, 7'h40, 1'b1, 1'b1);
`endif

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    skip(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode multi-digit seven-segment display, and the parametrised successor to our single-digit, static 0/1 display logic. It takes a packed hex value and a decimal-point mask, double-buffers them, and scans them onto NUM_DIGITS shared-segment digits at a programmable refresh rate. Each digit slot starts with a blanking interval to suppress ghosting. It sits between the board top level and any value-producing logic (gate demos, counters, ALUs).

## Interface
- NUM_DIGITS, 4: digits driven; legal range 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV (0 disables blanking).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  single-cycle strobe; captures value/dp_mask.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i → digit i (digit 0 = rightmost).
- dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i.
- digit_en  in  NUM_DIGITS  1 = digit i enabled; 0 = anode always off (live, not buffered).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low, at most one low at a time.
- frame_start  out  1  one-cycle pulse when the digit-0 slot begins.
- update_pending  out  1  pending buffer holds data not yet shown.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), pending buffer (value, dp), shadow buffer (value, dp), pend flag.
- cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the edge where cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1.
- load: pending ← {value, dp_mask}, pend ← 1.
- At a frame boundary with pend = 1 or load = 1:
  - shadow ← the load inputs if load = 1, else pending;
  - pend ← 0.
- A load on the boundary edge therefore goes directly to shadow and leaves pend = 0. Repeated loads within a frame overwrite pending; the last one wins. Digits never tear mid-frame.
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Digit idx is shown when cnt ≥ BLANK_CYCLES and digit_en[idx] = 1. Then an = ~(1<<idx), seg = decode(shadow nibble idx), dp = ~shadow_dp[idx].
- Otherwise the digit is blank: an all 1, seg = 1111111, dp = 1.
- update_pending = pend.

## Timing
- All outputs are registered: each output cycle reflects cnt/idx/shadow as sampled on the preceding edge, giving 1-cycle latency.
- Reset values: an all 1, seg = 1111111, dp = 1, frame_start = 0, update_pending = 0; cnt = 0, idx = 0, both buffers 0.
- frame_start is 1 in the cycle after an edge that samples cnt = 0 and idx = 0, including the first edge after reset release.
- Frame length is NUM_DIGITS × REFRESH_DIV cycles. A new shadow value is visible on seg from the first non-blank cycle of the next digit-0 slot.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronous). Scanning restarts at digit 0 and discards pending data.
- NUM_DIGITS = 1: idx stays 0 and every slot end is a frame boundary.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN:
  - Defined: digit i (i ≥ 1) is blanked when shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked by this rule, and dp of a blanked digit is also off.
  - Undefined: all enabled digits display, including leading zeros.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then free-run 64 cycles → an stays 1111 for the first 2 cycles of each slot, then 1110/1101/1011/0111 for 6 cycles each. frame_start pulses every 32 cycles. seg = 1000000 on shown digits.
- load value=16'h12AF, dp_mask=0100 mid-frame → update_pending = 1 until the boundary. Next frame shows digit0 = 0001110, digit1 = 0001000, digit2 = 0100100 with dp = 0, digit3 = 1111001.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed. load on the exact boundary edge → that value is shown in the next frame and update_pending stays 0.
- digit_en = 1010 → an never goes to 1110 or 1011. Digits 1 and 3 are scanned normally.
- Assert rst for 1 cycle during the digit-2 slot → outputs go to all 1 immediately, scan restarts at digit 0, and the previous display value is lost (shows 0).
- With SEG7_LEADING_ZERO_BLANK_EN, value = 16'h0050 → digits 3 and 2 are blank, digit 1 = 0010010, digit 0 = 1000000.
